// File: rtl/memory_stage_pkg.sv
// Shared MEM-stage types: execute/memory pipe records, data bus request/response,
// access-size encodings, FSM state encoding and alignment helpers.
package memory_stage_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  // Legacy state encodings, kept as constants so existing decoders still match.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    DONE = ST_DONE
  } mem_state_t;

  typedef struct packed {
    logic [63:0]       pc;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] aluout;
    logic [DATA_W-1:0] writedata;
    logic [4:0]        dst;
    msize_t            msize;
    logic              mem_unsigned;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic              memtoreg;
    logic              valid;
  } execute_data_t;

  typedef struct packed {
    logic [DATA_W-1:0] readdata;
    logic [ADDR_W-1:0] aluout;
    logic [4:0]        dst;
    logic              regwrite;
    logic              memtoreg;
    logic [63:0]       pc;
    logic [31:0]       instr;
    logic              valid;
  } memory_data_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    logic [7:0]        strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  // Byte-lane mask of an access of the given size starting at lane 0.
  function automatic logic [7:0] sizeMask(input msize_t size);
    case (size)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic isMisaligned(input logic [2:0] addrLow, input msize_t size);
    case (size)
      MSIZE1:  return 1'b0;
      MSIZE2:  return addrLow[0];
      MSIZE4:  return |addrLow[1:0];
      default: return |addrLow;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data bus between the MEM stage (master) and the memory owner (slave).
interface memory_stage_if;
  import memory_stage_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/memory_stage_align.sv
// mem_align: combinational lane steering. Store direction shifts write data
// into its byte lanes and builds the strobe; load direction shifts read data
// down, truncates to the access size and zero/sign extends.
module mem_align
  import memory_stage_pkg::*;
#(
  parameter bit LOAD_DIR = 1'b0
) (
  input  logic [2:0]        addrLow,
  input  msize_t            size,
  input  logic              isUnsigned,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic [7:0]        strobe
);

  logic [5:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] extended;

  assign shamt = {addrLow, 3'b000};

  // Extract and extend the addressed field of a load, or place a store in its lanes.
  always_comb begin
    shifted  = dataIn >> shamt;
    extended = '0;
    case (size)
      MSIZE1:  extended = isUnsigned ? {{(DATA_W-8){1'b0}},  shifted[7:0]}
                                     : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      MSIZE2:  extended = isUnsigned ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                     : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      MSIZE4:  extended = isUnsigned ? {{(DATA_W-32){1'b0}}, shifted[31:0]}
                                     : {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      default: extended = shifted;
    endcase

    if (LOAD_DIR) begin
      dataOut = extended;
      strobe  = '0;
    end else begin
      dataOut = dataIn << shamt;
      // Lanes shifted past byte 7 fall off the 8-bit result.
      strobe  = sizeMask(size) << addrLow;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage. Turns load/store ops into a single
// outstanding data-bus request, stalls upstream until data_ok, and formats
// load results. Non-memory ops pass through with zero latency.
// Optional: define MEM_MISALIGN_CHECK_EN to reject misaligned accesses
// without a bus request (flagged on misalign, regwrite suppressed).
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  execute_data_t         dataE,
  input  logic                  flush,
  memory_stage_if.master        dbus,
  output memory_data_t          dataM,
  output logic                  stallM,
  output logic                  misalign
);

  mem_state_t        state;
  dbus_req_t         reqQ;
  logic [DATA_W-1:0] resultQ;
  logic              flushedQ;

  logic              memop;
  logic              badAlign;
  logic              issue;
  logic [DATA_W-1:0] stData;
  logic [DATA_W-1:0] ldData;
  logic [7:0]        stStrobe;
  logic [7:0]        ldStrobe;

  assign memop = dataE.valid & (dataE.memread | dataE.memwrite);

`ifdef MEM_MISALIGN_CHECK_EN
  assign badAlign = isMisaligned(dataE.aluout[2:0], dataE.msize);
`else
  assign badAlign = 1'b0;
`endif

  assign issue = (state == IDLE) & memop & ~flush & ~badAlign;

  mem_align #(.LOAD_DIR(1'b0)) uStore (
    .addrLow    (dataE.aluout[2:0]),
    .size       (dataE.msize),
    .isUnsigned (1'b0),
    .dataIn     (dataE.writedata),
    .dataOut    (stData),
    .strobe     (stStrobe)
  );

  // Load direction works from the registered request so the lane select matches the bus access.
  mem_align #(.LOAD_DIR(1'b1)) uLoad (
    .addrLow    (reqQ.addr[2:0]),
    .size       (reqQ.size),
    .isUnsigned (dataE.mem_unsigned),
    .dataIn     (resultQ),
    .dataOut    (ldData),
    .strobe     (ldStrobe)
  );

  assign dbus.dreq = reqQ;

  // Request/response sequencing: issue from IDLE, hold in REQ until data_ok, one DONE cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      reqQ     <= '0;
      resultQ  <= '0;
      flushedQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state       <= REQ;
            reqQ.valid  <= 1'b1;
            reqQ.addr   <= dataE.aluout;
            reqQ.size   <= dataE.msize;
            reqQ.strobe <= dataE.memwrite ? stStrobe : ldStrobe;
            reqQ.data   <= stData;
            flushedQ    <= 1'b0;
          end
        end
        REQ: begin
          if (flush) flushedQ <= 1'b1;
          if (dbus.dresp.data_ok) begin
            resultQ    <= dbus.dresp.data;
            reqQ.valid <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          state    <= IDLE;
          flushedQ <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result formatting and stall generation for the current state.
  always_comb begin
    dataM.readdata = '0;
    dataM.aluout   = dataE.aluout;
    dataM.dst      = dataE.dst;
    dataM.regwrite = dataE.regwrite;
    dataM.memtoreg = dataE.memtoreg;
    dataM.pc       = dataE.pc;
    dataM.instr    = dataE.instr;
    dataM.valid    = 1'b0;
    stallM         = 1'b0;
    misalign       = 1'b0;

    case (state)
      IDLE: begin
        if (!memop) begin
          dataM.valid = dataE.valid & ~flush;
        end else if (flush) begin
          dataM.valid = 1'b0;
        end else if (badAlign) begin
          dataM.valid    = 1'b1;
          dataM.regwrite = 1'b0;
          misalign       = 1'b1;
        end else begin
          stallM = 1'b1;
        end
      end
      REQ: stallM = 1'b1;
      DONE: begin
        dataM.valid    = dataE.valid & ~flushedQ & ~flush;
        dataM.readdata = dataE.memread ? ldData : '0;
      end
      default: ;
    endcase

    // Reset must release upstream immediately even if EX still presents a memop.
    if (!resetn) begin
      stallM      = 1'b0;
      dataM.valid = 1'b0;
      misalign    = 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage; bus responses driven by hand.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  execute_data_t dataE;
  memory_data_t  dataM;
  logic          stallM;
  logic          misalign;

  int unsigned nChecks = 0;
  int unsigned nFails  = 0;

  memory_stage_if dbusIf();

  memory_stage uDut (
    .clk      (clk),
    .resetn   (resetn),
    .dataE    (dataE),
    .flush    (flush),
    .dbus     (dbusIf),
    .dataM    (dataM),
    .stallM   (stallM),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic execute_data_t mkOp(input logic [63:0] addr, input msize_t sz,
                                         input logic uns, input logic rd, input logic wr,
                                         input logic [63:0] wdata);
    execute_data_t e;
    e = '0;
    e.valid        = 1'b1;
    e.pc           = 64'h8000_0000 + addr;
    e.instr        = 32'h0000_0013;
    e.aluout       = addr;
    e.writedata    = wdata;
    e.dst          = 5'd7;
    e.msize        = sz;
    e.mem_unsigned = uns;
    e.memread      = rd;
    e.memwrite     = wr;
    e.regwrite     = rd;
    e.memtoreg     = rd;
    return e;
  endfunction

  // One memory op with data_ok in REQ cycle n; flush pulsed in REQ cycle flushAt (0 = none).
  task automatic memOp(input string tag, input execute_data_t e, input int n, input int flushAt,
                       input logic [63:0] raw, input logic [7:0] expStrobe,
                       input logic [63:0] expData, output logic [63:0] rd, output logic dvalid);
    int stalls;
    @(posedge clk);
    #1;
    dataE = e;
    flush = 1'b0;
    dbusIf.dresp = '0;
    #1;
    stalls = stallM ? 1 : 0;
    checkEq({tag, " idle dreq.valid"}, 64'(dbusIf.dreq.valid), 64'd0);
    checkEq({tag, " idle misalign"}, 64'(misalign), 64'd0);
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      #1;
      flush = (k == flushAt);
      dbusIf.dresp.data_ok = (k == n);
      dbusIf.dresp.data = raw;
      #1;
      if (stallM) stalls++;
      checkEq({tag, " req valid"},  64'(dbusIf.dreq.valid), 64'd1);
      checkEq({tag, " req addr"},   dbusIf.dreq.addr, e.aluout);
      checkEq({tag, " req strobe"}, 64'(dbusIf.dreq.strobe), 64'(expStrobe));
      checkEq({tag, " req data"},   dbusIf.dreq.data, expData);
      @(posedge clk);
    end
    #1;
    flush = 1'b0;
    dbusIf.dresp = '0;
    #1;
    checkEq({tag, " done stallM"}, 64'(stallM), 64'd0);
    checkEq({tag, " done dreq.valid"}, 64'(dbusIf.dreq.valid), 64'd0);
    checkEq({tag, " stall cycles"}, 64'(stalls), 64'(n + 1));
    rd = dataM.readdata;
    dvalid = dataM.valid;
    @(posedge clk);
    #1;
    dataE = '0;
  endtask

  initial begin
    logic [63:0] rd;
    logic        dv;

    dataE = '0;
    dbusIf.dresp = '0;

    // Reset state
    #2;
    checkEq("reset dreq.valid", 64'(dbusIf.dreq.valid), 64'd0);
    checkEq("reset dreq.strobe", 64'(dbusIf.dreq.strobe), 64'd0);
    checkEq("reset stallM", 64'(stallM), 64'd0);
    checkEq("reset misalign", 64'(misalign), 64'd0);
    checkEq("reset dataM.valid", 64'(dataM.valid), 64'd0);
    #10 resetn = 1'b1;

    // ALU pass-through
    @(posedge clk);
    #1;
    dataE = mkOp(64'h1234, MSIZE8, 1'b0, 1'b0, 1'b0, 64'h0);
    dataE.regwrite = 1'b1;
    #1;
    checkEq("alu aluout", dataM.aluout, 64'h1234);
    checkEq("alu stallM", 64'(stallM), 64'd0);
    checkEq("alu valid", 64'(dataM.valid), 64'd1);
    checkEq("alu regwrite", 64'(dataM.regwrite), 64'd1);
    checkEq("alu readdata", dataM.readdata, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkEq("alu dreq.valid", 64'(dbusIf.dreq.valid), 64'd0);
      checkEq("alu stallM hold", 64'(stallM), 64'd0);
    end
    dataE = '0;

    // Byte load, signed and unsigned
    memOp("lb", mkOp(64'h1003, MSIZE1, 1'b0, 1'b1, 1'b0, 64'h0), 3, 0,
          64'h0000_0000_8000_0000, 8'h00, 64'h0, rd, dv);
    checkEq("lb readdata", rd, 64'hFFFF_FFFF_FFFF_FF80);
    checkEq("lb valid", 64'(dv), 64'd1);
    memOp("lbu", mkOp(64'h1003, MSIZE1, 1'b1, 1'b1, 1'b0, 64'h0), 3, 0,
          64'h0000_0000_8000_0000, 8'h00, 64'h0, rd, dv);
    checkEq("lbu readdata", rd, 64'h0000_0000_0000_0080);
    checkEq("lbu valid", 64'(dv), 64'd1);

    // Halfword store in the top lanes
    memOp("sh", mkOp(64'h2006, MSIZE2, 1'b0, 1'b0, 1'b1, 64'hBEEF), 2, 0,
          64'h0, 8'hC0, 64'hBEEF_0000_0000_0000, rd, dv);
    checkEq("sh readdata", rd, 64'd0);
    checkEq("sh valid", 64'(dv), 64'd1);

    // Flush in the second REQ cycle: bus completes, result discarded
    memOp("flush lh", mkOp(64'h2002, MSIZE2, 1'b0, 1'b1, 1'b0, 64'h0), 3, 2,
          64'h0000_0000_8001_0000, 8'h00, 64'h0, rd, dv);
    checkEq("flush valid", 64'(dv), 64'd0);

    // Following op proceeds normally
    memOp("ld", mkOp(64'h3008, MSIZE8, 1'b0, 1'b1, 1'b0, 64'h0), 1, 0,
          64'h0123_4567_89AB_CDEF, 8'h00, 64'h0, rd, dv);
    checkEq("ld readdata", rd, 64'h0123_4567_89AB_CDEF);
    checkEq("ld valid", 64'(dv), 64'd1);

    // Asynchronous reset while in REQ
    @(posedge clk);
    #1;
    dataE = mkOp(64'h1000, MSIZE4, 1'b0, 1'b1, 1'b0, 64'h0);
    #1;
    checkEq("rst pre stallM", 64'(stallM), 64'd1);
    @(posedge clk);
    #2;
    checkEq("rst in REQ", 64'(dbusIf.dreq.valid), 64'd1);
    #1 resetn = 1'b0;
    #1;
    checkEq("rst dreq.valid", 64'(dbusIf.dreq.valid), 64'd0);
    checkEq("rst stallM", 64'(stallM), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    dataE = '0;
    memOp("lw", mkOp(64'h1004, MSIZE4, 1'b0, 1'b1, 1'b0, 64'h0), 2, 0,
          64'h1234_5678_0000_0000, 8'h00, 64'h0, rd, dv);
    checkEq("lw readdata", rd, 64'h0000_0000_1234_5678);
    checkEq("lw valid", 64'(dv), 64'd1);
    memOp("lwneg", mkOp(64'h1000, MSIZE4, 1'b0, 1'b1, 1'b0, 64'h0), 1, 0,
          64'h0000_0000_FFFF_FFFE, 8'h00, 64'h0, rd, dv);
    checkEq("lwneg readdata", rd, 64'hFFFF_FFFF_FFFF_FFFE);

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned doubleword: completes in one cycle, no bus request
    @(posedge clk);
    #1;
    dataE = mkOp(64'h3004, MSIZE8, 1'b0, 1'b1, 1'b0, 64'h0);
    #1;
    checkEq("mis misalign", 64'(misalign), 64'd1);
    checkEq("mis stallM", 64'(stallM), 64'd0);
    checkEq("mis valid", 64'(dataM.valid), 64'd1);
    checkEq("mis regwrite", 64'(dataM.regwrite), 64'd0);
    checkEq("mis dreq.valid", 64'(dbusIf.dreq.valid), 64'd0);
    @(posedge clk);
    #1;
    checkEq("mis no request", 64'(dbusIf.dreq.valid), 64'd0);
    dataE = '0;
    memOp("aligned ld", mkOp(64'h3008, MSIZE8, 1'b0, 1'b1, 1'b0, 64'h0), 1, 0,
          64'hCAFE_F00D_1234_5678, 8'h00, 64'h0, rd, dv);
    checkEq("aligned ld readdata", rd, 64'hCAFE_F00D_1234_5678);
`else
    // Misaligned doubleword store issued as-is; upper strobe lanes dropped
    memOp("mis sd", mkOp(64'h3004, MSIZE8, 1'b0, 1'b0, 1'b1, 64'h1122_3344_5566_7788), 1, 0,
          64'h0, 8'hF0, 64'h5566_7788_0000_0000, rd, dv);
    checkEq("mis sd valid", 64'(dv), 64'd1);
    checkEq("mis sd readdata", rd, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage, directly downstream of execute; consumes execute_data_t and produces memory_data_t for writeback.
- Converts load/store ops into single-outstanding requests on the data bus (dbus_req_t / dbus_resp_t), stalling the pipeline until the bus completes.
- Aligns store data and builds byte strobes; extracts, sign-extends or zero-extends load data.
- Non-memory ops pass through combinationally with zero latency.

Parameters:
- DATA_W, 64, data bus / register width
- ADDR_W, 64, address width

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- dataE  in  execute_data_t  EX/MEM register contents (aluout = address, writedata, msize, mem_unsigned, memread, memwrite, valid, ...)
- flush  in  1  discard the op currently in MEM
- dreq  out  dbus_req_t  {valid, addr, size, strobe, data}
- dresp  in  dbus_resp_t  {data_ok, data}
- dataM  out  memory_data_t  result to MEM/WB (readdata, aluout, dst, regwrite, memtoreg, pc, instr, valid)
- stallM  out  1  hold all upstream stages
- misalign  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset (resetn=0, async) → IDLE; dreq all zero; result register 0; flushed flag 0; stallM=0; misalign=0.
- memop = dataE.valid & (memread | memwrite).
- IDLE, !memop: stallM=0; dataM = dataE fields passed through; readdata=0. Stay in IDLE.
- IDLE, memop & !flush: stallM=1. Next edge: dreq registers loaded and state → REQ.
  - addr = aluout.
  - size = msize.
  - strobe = size mask (1/3/F/FF) << addr[2:0].
  - data = writedata << (8*addr[2:0]).
  - For loads, strobe=0.
- IDLE, memop & flush: no request issued; dataM.valid=0.
- REQ: dreq.valid=1; stallM=1. Request fields stay stable until data_ok.
  - On dresp.data_ok: capture dresp.data into result register; dreq.valid→0 on the next edge; state → DONE.
  - The request is never withdrawn.
- REQ with flush (any cycle): set flushed flag. The bus transaction still completes; the DONE cycle then drives dataM.valid=0.
- DONE: stallM=0; dataM = dataE fields plus readdata; state → IDLE on the next edge. Upstream advances at the end of DONE, so the same op is never reissued.
- Load extraction:
  - shifted = raw >> (8*addr[2:0]).
  - Truncate to 8/16/32/64 bits.
  - mem_unsigned=1 → zero-extend; otherwise sign-extend from the top bit of the truncated value.
- Stores: dataM.readdata=0; regwrite passes through unchanged.
- Latency: memop = 2 + N cycles, where N = REQ cycles waited before data_ok (N≥1); non-memop = 0.
- data_ok arriving in IDLE or DONE is ignored.
- Reset mid-REQ: returns to IDLE, dreq.valid=0 immediately; the bus owner is also reset.

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- Defined:
  - A memop whose addr is not a multiple of the access size issues no bus request.
  - It completes in one cycle: misalign=1, dataM.valid=1, regwrite forced 0, stallM=0.
- Undefined:
  - misalign tied 0.
  - Misaligned addresses are issued as-is; strobe bits shifted past bit 7 are dropped.

Decomposition:
- Shared package (pipes/common) holds:
  - memory_data_t and msize_t.
  - msize encodings: MSIZE1=0, MSIZE2=1, MSIZE4=2, MSIZE8=3.
  - dbus_req_t / dbus_resp_t reuse the existing common definitions.
  - mem_state_t enum (IDLE/REQ/DONE).
- One combinational sub-module, mem_align: store shift/strobe generation and load extract/extend. It is instantiated once for each direction function.

Test Plan:
- ALU op: dataE.valid=1, memread=memwrite=0, aluout=0x1234 → same-cycle dataM.aluout=0x1234; stallM=0; dreq.valid never 1.
- Byte load, signed:
  - Stimulus: addr=0x1003, msize=MSIZE1, mem_unsigned=0; bus returns 0x00000000_80000000 after 3 REQ cycles.
  - Required: readdata=0xFFFFFFFF_FFFFFF80; stallM high 4 cycles then low in DONE.
  - Repeat with mem_unsigned=1 → readdata=0x80.
- Halfword store:
  - Stimulus: addr=0x2006, writedata=0xBEEF.
  - Required: dreq.strobe=0xC0, dreq.data=0xBEEF0000_00000000, held stable until data_ok; dataM.readdata=0.
- Flush mid-REQ: flush pulsed in the 2nd REQ cycle → dreq.valid stays 1 until data_ok; DONE drives dataM.valid=0; next op proceeds normally.
- Async reset: resetn low in REQ → dreq.valid=0 and stallM=0 without a clock edge; after release, a new load completes correctly.
- With MEM_MISALIGN_CHECK_EN:
  - Doubleword load at addr=0x3004 → misalign=1, no dreq.valid, regwrite=0, 1-cycle completion.
  - Aligned addr=0x3008 → normal bus access.
